uart_block_responder: RTL
=========================

UART_BLOCK_RESPONDER -- requirements
Module: uart_block_responder

Interface
REQ-001 Parameter BLK, default 32: bytes per block received from the UART RX FIFO.
REQ-002 Parameter IDX_W, default 5: index width; SHALL satisfy 2^IDX_W >= BLK.
REQ-003 clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx_empty  input  1  RX FIFO empty flag.
REQ-006 r_data  input  8  RX FIFO head byte, valid whenever rx_empty=0 (first-word fall-through).
REQ-007 rd_uart  output  1  RX FIFO pop strobe.
REQ-008 tx_full  input  1  TX FIFO full flag.
REQ-009 wr_uart  output  1  TX FIFO push strobe.
REQ-010 w_data  output  8  byte pushed to the TX FIFO when wr_uart=1.
REQ-011 busy  output  1  high in SEND or CHK.
REQ-012 blk_cnt  output  8  count of completed blocks, wraps from 255 to 0.

Function
REQ-013 The block SHALL be an FSM with three states: LOAD (collect block), SEND (return processed block), CHK (return checksum).
REQ-014 In LOAD, rd_uart SHALL equal ~rx_empty combinationally; on each cycle with rd_uart=1, r_data SHALL be written to buf[idx], idx SHALL increment, and sum SHALL become sum+r_data mod 256.
REQ-015 When the byte at idx=BLK-1 is popped, the FSM SHALL enter SEND on the next edge with idx cleared to 0.
REQ-016 In SEND, wr_uart SHALL equal ~tx_full combinationally, with w_data = ~buf[idx] (image negative, 255-x); idx SHALL increment on each push.
REQ-017 After the push at idx=BLK-1, the FSM SHALL enter CHK with idx=0.
REQ-018 In CHK, wr_uart SHALL equal ~tx_full with w_data=sum; on that push the FSM SHALL return to LOAD, sum SHALL clear to 0, and blk_cnt SHALL increment.
REQ-019 rd_uart SHALL be 0 outside LOAD; wr_uart SHALL be 0 in LOAD.
REQ-020 Throughput SHALL be one byte per cycle in each direction when the FIFO flags permit, with no bubble cycles between bytes.
REQ-021 Latency SHALL be: the first SEND push occurs 1 cycle after the last LOAD pop, provided tx_full=0.
REQ-022 A stalled FIFO (rx_empty=1 in LOAD, tx_full=1 in SEND/CHK) SHALL hold all state unchanged, with no drop or duplicate, for any duration.
REQ-023 Bytes arriving in the RX FIFO during SEND/CHK SHALL remain in the FIFO untouched until the next LOAD.
REQ-024 Arithmetic: sum SHALL be 8-bit modulo-256; idx SHALL never exceed BLK-1.
REQ-025 buf SHALL be a BLK x 8 register/RAM array; it SHALL not require reset.

Reset
REQ-026 While reset=1, the state SHALL be LOAD with idx=0, sum=0, blk_cnt=0, busy=0, rd_uart=0, wr_uart=0, and w_data=0.
REQ-027 A reset asserted mid-LOAD or mid-SEND SHALL abandon the partial block immediately; after release, the next popped byte SHALL be stored at buf[0].
REQ-028 The first rd_uart=1 after reset SHALL occur no earlier than the first rising edge after reset deassertion.

Verification
REQ-029 Load 32 bytes of 0x00..0x1F with tx_full=0 -> 32 pushes of 0xFF..0xE0, then a checksum push of 0xF0; blk_cnt=1; busy low after the checksum push.
REQ-030 Load 32 bytes of 0xFF -> 32 pushes of 0x00, then a checksum of 0xE0 (wrap-around of the modulo-256 sum).
REQ-031 Drive rx_empty=1 every other cycle, and tx_full=1 for 10 cycles at SEND idx=5 -> the output sequence is identical to the unstalled case; wr_uart=0 throughout the stall.
REQ-032 Assert reset after 17 pops, release, then load a full block of 0x10 -> output is 32 x 0xEF and a checksum of 0x00; blk_cnt=1.
REQ-033 Run 256 back-to-back blocks -> blk_cnt wraps to 0; rd_uart never asserts in SEND/CHK.
REQ-034 Hold rx_empty=0 continuously during SEND -> rd_uart stays 0 until CHK completes, then pops on the first LOAD cycle.

Source files
------------

// File: rtl/uart_block_responder.sv
// Collects a block of bytes from the UART RX FIFO, returns each byte inverted,
// then returns the mod-256 sum of the received block.
module uart_block_responder #(
    parameter int unsigned BLK   = 32,
    parameter int unsigned IDX_W = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_empty,
    input  logic [7:0] r_data,
    output logic       rd_uart,
    input  logic       tx_full,
    output logic       wr_uart,
    output logic [7:0] w_data,
    output logic       busy,
    output logic [7:0] blk_cnt
);

    typedef enum logic [1:0] {StLoad, StSend, StChk} state_t;

    localparam logic [IDX_W-1:0] LastIdx = IDX_W'(BLK - 1);

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       sum_q, sum_d;
    logic [7:0]       cnt_q, cnt_d;
    logic             run_q;
    logic [7:0]       blk_buf [BLK];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StLoad;
            idx_q   <= '0;
            sum_q   <= '0;
            cnt_q   <= '0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            sum_q   <= sum_d;
            cnt_q   <= cnt_d;
            run_q   <= 1'b1;
        end
    end

    // Block storage carries no reset; it is always overwritten before being read.
    always_ff @(posedge clk) begin
        if (rd_uart) begin
            blk_buf[idx_q] <= r_data;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        sum_d   = sum_q;
        cnt_d   = cnt_q;
        rd_uart = 1'b0;
        wr_uart = 1'b0;
        w_data  = 8'h00;
        case (state_q)
            StLoad: begin
                // run_q keeps the first pop off until a clock edge has passed after reset
                rd_uart = run_q & ~rx_empty;
                if (rd_uart) begin
                    sum_d = sum_q + r_data;
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StSend;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StSend: begin
                wr_uart = ~tx_full;
                w_data  = ~blk_buf[idx_q];
                if (wr_uart) begin
                    if (idx_q == LastIdx) begin
                        idx_d   = '0;
                        state_d = StChk;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            StChk: begin
                wr_uart = ~tx_full;
                w_data  = sum_q;
                if (wr_uart) begin
                    state_d = StLoad;
                    sum_d   = '0;
                    cnt_d   = cnt_q + 1'b1;
                end
            end
            default: state_d = StLoad;
        endcase
    end

    assign busy    = (state_q != StLoad);
    assign blk_cnt = cnt_q;

endmodule
